sar_seq_ctrl: RTL
=================

Name: sar_seq_ctrl

Overview:
- Conversion sequencer for the 6-bit SAR ADC datapath (comparator plus capacitive DAC).
- Drives the sample, comp_en, rs and d1..d6/d1b..d6b controls in the order a binary search needs, reads the comparator decision, and returns a 6-bit result with a done pulse.
- Sits between the digital host (start/abort/continuous control) and the analog macro.

Parameters:
- SAMPLE_CYCLES, 2, cycles sample is held high (1..15).
- SETTLE_CYCLES, 1, cycles the DAC settles after each trial-bit update, before comp_en (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  conversion request; sampled only in IDLE
- cont  in  1  continuous mode: after DONE, restart without start
- abort  in  1  synchronous abort; returns to IDLE next cycle
- comp_out  in  1  comparator decision; 1 = Vin >= DAC
- rs  out  1  comparator/DAC reset strobe
- sample  out  1  track phase of the sampling switch
- comp_en  out  1  comparator strobe
- d1..d6  out  1 each  DAC trial bits; d1 = MSB (weight 32), d6 = LSB
- d1b..d6b  out  1 each  complements; dNb = ~dN at all times, including reset
- result  out  6  last completed code; MSB = d1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when result updates
- overrun  out  1  one-cycle pulse when start is seen while busy

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, rs=0, sample=0, comp_en=0, d1..d6=0, d1b..d6b=1, result=0, busy=0, done=0, overrun=0. All outputs are registered.
- FSM states: IDLE, RST, SAMP, SETTLE, COMP, DONE. Bit index k runs 1..6.
- IDLE:
  - Go to RST if start=1.
  - Otherwise remain.
- RST:
  - 1 cycle with rs=1 and d=000000.
  - Then SAMP.
- SAMP:
  - sample=1 for SAMPLE_CYCLES cycles; d=000000.
  - Then SETTLE with k=1 and dk set to 1.
- SETTLE:
  - Hold the trial code for SETTLE_CYCLES cycles.
  - Then COMP.
- COMP:
  - comp_en=1 for exactly 1 cycle.
  - comp_out is captured on the clock edge that ends this cycle.
  - If comp_out=0, clear dk; otherwise keep it.
  - If k<6, set bit k+1 on the same edge, increment k, go to SETTLE.
  - If k=6, load result with the final code and go to DONE.
- DONE:
  - done=1 for 1 cycle.
  - d returns to 000000 on exit.
  - Next state is RST if cont=1, otherwise IDLE. start is not needed in this case.
- Latency with defaults: start sampled at edge E0; done is high in cycle 16 after E0, i.e. 1 + SAMPLE_CYCLES + 6*(SETTLE_CYCLES+1) + 1.
- Continuous mode with defaults: done repeats every 16 cycles.
- start while busy (including during DONE):
  - start is ignored.
  - overrun=1 for 1 cycle per cycle start is high.
  - The conversion is unaffected.
- abort (any non-IDLE state):
  - Next state is IDLE; all strobes go low and d=000000.
  - result is unchanged and there is no done pulse.
  - abort has priority over cont and over start.
- abort in IDLE has no effect.
- comp_out is ignored outside COMP. sample, comp_en and rs are mutually exclusive, never high in the same cycle.
- Async reset mid-conversion: all outputs take their reset values immediately and the partial code is discarded.

Test Plan:
- Comparator model with Vin code 43: pulse start → d sequence 100000, 110000, 101000, 101100, 101010, 101011; result=6'b101011, done in cycle 16, dNb always ~dN.
- Extremes:
  - Vin=0 (comp_out always 0) → result=000000.
  - Vin=63 (always 1) → result=111111.
  - In both cases comp_en is pulsed exactly 6 times.
- cont=1 held, Vin=20 → done every 16 cycles with result=010100 each time; rs precedes each sample phase by 1 cycle.
- start re-asserted 3 cycles into a conversion → overrun pulses 1 cycle, result and done timing unchanged, no second conversion queued.
- abort during the COMP of bit 3 → IDLE next cycle, d=000000, result holds its previous value, no done; a following start converts normally.
- rst_n low during SETTLE of bit 4, SAMPLE_CYCLES=3, SETTLE_CYCLES=2 → all outputs at reset values asynchronously; after release, start gives done at cycle 1+3+18+1=23.

Source files
------------

// File: rtl/sar_seq_ctrl_if.sv
// rtl/sar_seq_ctrl_if.sv - host and analog-macro signal bundle for the SAR conversion sequencer
interface sar_seq_ctrl_if;
    logic       start;
    logic       cont;
    logic       abort;
    logic       comp_out;
    logic       rs;
    logic       sample;
    logic       comp_en;
    logic       d1, d2, d3, d4, d5, d6;
    logic       d1b, d2b, d3b, d4b, d5b, d6b;
    logic [5:0] result;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output start, cont, abort, comp_out,
        input  rs, sample, comp_en,
        input  d1, d2, d3, d4, d5, d6,
        input  d1b, d2b, d3b, d4b, d5b, d6b,
        input  result, busy, done, overrun
    );

    modport slave (
        input  start, cont, abort, comp_out,
        output rs, sample, comp_en,
        output d1, d2, d3, d4, d5, d6,
        output d1b, d2b, d3b, d4b, d5b, d6b,
        output result, busy, done, overrun
    );
endinterface

// File: rtl/sar_seq_ctrl.sv
// rtl/sar_seq_ctrl.sv - binary-search sequencer driving a 6-bit SAR ADC comparator and capacitive DAC
module sar_seq_ctrl #(
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sar_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SAMP, S_SETTLE, S_COMP, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] k_q, k_d;
    logic [5:0] code_q, code_d;
    logic [5:0] code_b_q, code_b_d;
    logic [5:0] result_q, result_d;
    logic       rs_q, rs_d;
    logic       sample_q, sample_d;
    logic       comp_en_q, comp_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;
    logic [5:0] bit_mask;

    assign bit_mask = 6'b100000 >> k_q;

    // Outputs are computed from the next state so every strobe lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        code_d    = code_q;
        result_d  = result_q;
        rs_d      = 1'b0;
        sample_d  = 1'b0;
        comp_en_d = 1'b0;
        done_d    = 1'b0;
        overrun_d = bus.start && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RST;
                    rs_d    = 1'b1;
                    code_d  = 6'b000000;
                end
            end
            S_RST: begin
                state_d  = S_SAMP;
                sample_d = 1'b1;
                cnt_d    = 4'(SAMPLE_CYCLES - 1);
                code_d   = 6'b000000;
            end
            S_SAMP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    sample_d = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                    k_d     = 3'd0;
                    code_d  = 6'b100000;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = S_COMP;
                    comp_en_d = 1'b1;
                end
            end
            S_COMP: begin
                code_d = bus.comp_out ? code_q : (code_q & ~bit_mask);
                if (k_q != 3'd5) begin
                    code_d  = code_d | (bit_mask >> 1);
                    k_d     = k_q + 3'd1;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end else begin
                    result_d = code_d;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                code_d = 6'b000000;
                if (bus.cont) begin
                    state_d = S_RST;
                    rs_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = 6'b000000;
            end
        endcase

        // Abort wins over cont and start; the last good result is kept.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            code_d    = 6'b000000;
            result_d  = result_q;
            rs_d      = 1'b0;
            sample_d  = 1'b0;
            comp_en_d = 1'b0;
            done_d    = 1'b0;
        end

        busy_d   = (state_d != S_IDLE);
        code_b_d = ~code_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            k_q       <= 3'd0;
            code_q    <= 6'b000000;
            code_b_q  <= 6'b111111;
            result_q  <= 6'b000000;
            rs_q      <= 1'b0;
            sample_q  <= 1'b0;
            comp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            code_q    <= code_d;
            code_b_q  <= code_b_d;
            result_q  <= result_d;
            rs_q      <= rs_d;
            sample_q  <= sample_d;
            comp_en_q <= comp_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rs      = rs_q;
    assign bus.sample  = sample_q;
    assign bus.comp_en = comp_en_q;
    assign bus.d1      = code_q[5];
    assign bus.d2      = code_q[4];
    assign bus.d3      = code_q[3];
    assign bus.d4      = code_q[2];
    assign bus.d5      = code_q[1];
    assign bus.d6      = code_q[0];
    assign bus.d1b     = code_b_q[5];
    assign bus.d2b     = code_b_q[4];
    assign bus.d3b     = code_b_q[3];
    assign bus.d4b     = code_b_q[2];
    assign bus.d5b     = code_b_q[1];
    assign bus.d6b     = code_b_q[0];
    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule
